// File: rtl/async_fifo_wr_ctrl.sv
// rtl/async_fifo_wr_ctrl.sv - write-side pointer, Gray publish and full/level/overflow flags for the dual-clock FIFO
// Optional build macro: WR_OVF_STICKY_EN (overflow holds until ovf_clr instead of pulsing).
module async_fifo_wr_ctrl #(
  parameter int ADDR_W       = 3,
  parameter int AFULL_THRESH = 6
) (
  input  logic              w_clk,
  input  logic              w_resetn,
  input  logic              w_enbl,
  input  logic [ADDR_W:0]   rd_gray_sync,
  input  logic              ovf_clr,
  output logic              w_mem_en,
  output logic [ADDR_W-1:0] w_addr,
  output logic [ADDR_W:0]   wr_gray_ptr,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   wr_level,
  output logic              overflow
);

  localparam int PW = ADDR_W + 1;
  localparam logic [ADDR_W:0] AFULL_L = PW'(AFULL_THRESH);

  logic [ADDR_W:0] wr_bin_q, wr_bin_d;
  logic [ADDR_W:0] wr_gray_q, wr_gray_d;
  logic [ADDR_W:0] level_q, level_d;
  logic            full_q, full_d;
  logic            afull_q, afull_d;
  logic            ovf_q, ovf_d;

  logic            push;
  logic            ovf_ev;
  logic [ADDR_W:0] rd_bin;
  logic [ADDR_W:0] full_gray;

  assign push   = w_enbl & ~full_q;
  assign ovf_ev = w_enbl & full_q;

  // Gray-to-binary as an XOR prefix from the MSB down.
  always_comb begin
    rd_bin         = '0;
    rd_bin[ADDR_W] = rd_gray_sync[ADDR_W];
    for (int i = ADDR_W - 1; i >= 0; i--) begin
      rd_bin[i] = rd_bin[i+1] ^ rd_gray_sync[i];
    end
  end

  // A full FIFO's write Gray pointer differs from the read one in its top two bits.
  assign full_gray = {~rd_gray_sync[ADDR_W:ADDR_W-1], rd_gray_sync[ADDR_W-2:0]};

  always_comb begin
    wr_bin_d  = wr_bin_q + {{ADDR_W{1'b0}}, push};
    wr_gray_d = wr_bin_d ^ (wr_bin_d >> 1);
    level_d   = wr_bin_d - rd_bin;
    full_d    = (wr_gray_d == full_gray);
    afull_d   = (level_d >= AFULL_L);
`ifdef WR_OVF_STICKY_EN
    ovf_d     = ovf_ev ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
`else
    ovf_d     = ovf_ev;
`endif
  end

`ifndef WR_OVF_STICKY_EN
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
`endif

  always_ff @(posedge w_clk or negedge w_resetn) begin
    if (!w_resetn) begin
      wr_bin_q  <= '0;
      wr_gray_q <= '0;
      level_q   <= '0;
      full_q    <= 1'b0;
      afull_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      wr_bin_q  <= wr_bin_d;
      wr_gray_q <= wr_gray_d;
      level_q   <= level_d;
      full_q    <= full_d;
      afull_q   <= afull_d;
      ovf_q     <= ovf_d;
    end
  end

  assign w_mem_en    = push;
  assign w_addr      = wr_bin_q[ADDR_W-1:0];
  assign wr_gray_ptr = wr_gray_q;
  assign full        = full_q;
  assign almost_full = afull_q;
  assign wr_level    = level_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// tb/tb_async_fifo_wr_ctrl.sv - self-checking bench for async_fifo_wr_ctrl (ADDR_W=3, AFULL_THRESH=6)
module tb_async_fifo_wr_ctrl;

  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int THR   = 6;

  logic          w_clk = 1'b0;
  logic          w_resetn = 1'b0;
  logic          w_enbl = 1'b0;
  logic [AW:0]   rd_gray_sync = '0;
  logic          ovf_clr = 1'b0;
  logic          w_mem_en;
  logic [AW-1:0] w_addr;
  logic [AW:0]   wr_gray_ptr;
  logic          full;
  logic          almost_full;
  logic [AW:0]   wr_level;
  logic          overflow;

  async_fifo_wr_ctrl #(.ADDR_W(AW), .AFULL_THRESH(THR)) dut (
    .w_clk(w_clk), .w_resetn(w_resetn), .w_enbl(w_enbl), .rd_gray_sync(rd_gray_sync),
    .ovf_clr(ovf_clr), .w_mem_en(w_mem_en), .w_addr(w_addr), .wr_gray_ptr(wr_gray_ptr),
    .full(full), .almost_full(almost_full), .wr_level(wr_level), .overflow(overflow)
  );

  always #5 w_clk = ~w_clk;

  int errors = 0;
  int checks = 0;

  // Reference model: total words written/read as plain counters.
  int m_wr, m_rd, m_level;
  bit m_full, m_afull, m_ovf;
  bit s_mem_en;
  int s_addr;

  function automatic int gray(input int b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wr = 0; m_rd = 0; m_level = 0; m_full = 0; m_afull = 0; m_ovf = 0;
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, ".gray"},  int'(wr_gray_ptr), gray(m_wr % 16));
    chk({tag, ".addr"},  int'(w_addr), m_wr % DEPTH);
    chk({tag, ".full"},  int'(full), int'(m_full));
    chk({tag, ".afull"}, int'(almost_full), int'(m_afull));
    chk({tag, ".level"}, int'(wr_level), m_level);
    chk({tag, ".ovf"},   int'(overflow), int'(m_ovf));
  endtask

  // One cycle: drive after negedge, check strobe before the edge, check registers after it.
  task automatic step(input string tag, input bit en, input int rd, input bit clr);
    bit push, ev;
    @(negedge w_clk);
    w_enbl = en;
    m_rd = rd;
    rd_gray_sync = 4'(gray(rd % 16));
    ovf_clr = clr;
    #1;
    push = en && !m_full;
    ev = en && m_full;
    s_mem_en = w_mem_en;
    s_addr = int'(w_addr);
    chk({tag, ".mem_en"}, int'(w_mem_en), int'(push));
    @(posedge w_clk);
    m_wr += int'(push);
    m_level = m_wr - m_rd;
    m_full = (m_level == DEPTH);
    m_afull = (m_level >= THR);
`ifdef WR_OVF_STICKY_EN
    m_ovf = ev ? 1'b1 : (clr ? 1'b0 : m_ovf);
`else
    m_ovf = ev;
`endif
    #1;
    chk_regs(tag);
  endtask

  task automatic do_reset(input string tag);
    w_resetn = 1'b0;
    #1;
    model_reset();
    chk({tag, ".gray"},  int'(wr_gray_ptr), 0);
    chk({tag, ".addr"},  int'(w_addr), 0);
    chk({tag, ".full"},  int'(full), 0);
    chk({tag, ".afull"}, int'(almost_full), 0);
    chk({tag, ".level"}, int'(wr_level), 0);
    chk({tag, ".ovf"},   int'(overflow), 0);
    @(negedge w_clk);
    w_enbl = 1'b0; rd_gray_sync = '0; ovf_clr = 1'b0;
    w_resetn = 1'b1;
  endtask

  typedef struct {
    bit en;
    bit x_mem_en; int x_addr; int x_gray; bit x_full; bit x_afull; int x_level; bit x_ovf;
  } vec_t;

  vec_t vt[9];
  int prev_gray;
  bit seen_wrap;

  initial begin
    vt[0] = '{1, 1, 0, 4'b0001, 0, 0, 1, 0};
    vt[1] = '{1, 1, 1, 4'b0011, 0, 0, 2, 0};
    vt[2] = '{1, 1, 2, 4'b0010, 0, 0, 3, 0};
    vt[3] = '{1, 1, 3, 4'b0110, 0, 0, 4, 0};
    vt[4] = '{1, 1, 4, 4'b0111, 0, 0, 5, 0};
    vt[5] = '{1, 1, 5, 4'b0101, 0, 1, 6, 0};
    vt[6] = '{1, 1, 6, 4'b0100, 0, 1, 7, 0};
    vt[7] = '{1, 1, 7, 4'b1100, 1, 1, 8, 0};
    vt[8] = '{1, 0, 0, 4'b1100, 1, 1, 8, 1};

    model_reset();
    repeat (2) @(posedge w_clk);
    do_reset("rst0");

    // 8 back-to-back writes, then the first write attempt while full
    for (int i = 0; i < 9; i++) begin
      step($sformatf("t1m[%0d]", i), vt[i].en, 0, 0);
      chk($sformatf("t1[%0d].mem_en", i), int'(s_mem_en), int'(vt[i].x_mem_en));
      chk($sformatf("t1[%0d].addr", i),   s_addr, vt[i].x_addr);
      chk($sformatf("t1[%0d].gray", i),   int'(wr_gray_ptr), vt[i].x_gray);
      chk($sformatf("t1[%0d].full", i),   int'(full), int'(vt[i].x_full));
      chk($sformatf("t1[%0d].afull", i),  int'(almost_full), int'(vt[i].x_afull));
      chk($sformatf("t1[%0d].level", i),  int'(wr_level), vt[i].x_level);
      chk($sformatf("t1[%0d].ovf", i),    int'(overflow), int'(vt[i].x_ovf));
    end

    // Two more writes while full, then idle and clear
    step("t2a", 1, 0, 0);
    chk("t2a.ovf_c", int'(overflow), 1);
    step("t2b", 1, 0, 0);
    chk("t2b.mem_en_c", int'(s_mem_en), 0);
    chk("t2b.gray_c", int'(wr_gray_ptr), 4'b1100);
    step("t2c", 0, 0, 0);
`ifdef WR_OVF_STICKY_EN
    chk("t2c.ovf_c", int'(overflow), 1);
`else
    chk("t2c.ovf_c", int'(overflow), 0);
`endif
    step("t2d", 0, 0, 1);
    chk("t2d.ovf_c", int'(overflow), 0);

    // Read pointer jumps to 3 while full
    step("t3a", 0, 3, 0);
    chk("t3a.full_c", int'(full), 0);
    chk("t3a.level_c", int'(wr_level), 5);
    step("t3b", 1, 3, 0);
    chk("t3b.mem_en_c", int'(s_mem_en), 1);
    chk("t3b.addr_c", s_addr, 0);
    chk("t3b.gray_c", int'(wr_gray_ptr), gray(9));

    // Wrap with reader two behind
    do_reset("rst4");
    prev_gray = 0;
    seen_wrap = 0;
    for (int i = 0; i < 20; i++) begin
      step($sformatf("t4[%0d]", i), 1, (m_wr >= 2) ? m_wr - 2 : 0, 0);
      chk($sformatf("t4[%0d].onebit", i), $countones(4'(prev_gray) ^ wr_gray_ptr), 1);
      chk($sformatf("t4[%0d].nofull", i), int'(full), 0);
      if (m_wr % 16 == 0) begin
        chk("t4.wrap_from", prev_gray, 4'b1000);
        chk("t4.wrap_to", int'(wr_gray_ptr), 0);
        seen_wrap = 1;
      end
      prev_gray = int'(wr_gray_ptr);
    end
    chk("t4.wrap_seen", int'(seen_wrap), 1);

    // Same-edge write and read advance at level 7
    do_reset("rst5");
    for (int i = 0; i < 7; i++) step("t5fill", 1, 0, 0);
    step("t5", 1, 1, 0);
    chk("t5.level_c", int'(wr_level), 7);
    chk("t5.full_c", int'(full), 0);

    // Asynchronous reset mid-burst at level 5
    do_reset("rst6a");
    for (int i = 0; i < 5; i++) step("t6fill", 1, 0, 0);
    chk("t6.level_c", int'(wr_level), 5);
    @(posedge w_clk);
    #3;
    do_reset("rst6");
    step("t6w", 1, 0, 0);
    chk("t6w.addr_c", s_addr, 0);

    // Randomised traffic against the counter model
    do_reset("rst7");
    for (int i = 0; i < 400; i++) begin
      int rd;
      rd = m_rd;
      if (m_rd < m_wr && $urandom_range(2, 0) == 0) rd = m_rd + 1;
      step($sformatf("rnd[%0d]", i), ($urandom_range(3, 0) != 0), rd, ($urandom_range(7, 0) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
